dense_sequencer: RTL and testbench

Control and scheduling block for the fully connected (dense) layer. It walks the pooled feature map in the order channel (outer), row, col (inner) and generates the weight-memory addresses for each beat. It also produces the valid, last-column and done qualifiers consumed by the dense compute unit. It owns the start/busy/done handshake with the top-level layer FSM and honours a stall from the compute side.

---
 rtl/dense_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_dense_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_sequencer.sv
// dense_sequencer: walks the pooled map channel/row/col and issues weight-memory beats for the dense layer.
// Latency: busy one cycle after start, first beat in that same cycle; valid_out trails each beat by MEM_LAT.
// Backpressure: stall freezes counters, addresses and the issue pipeline; weight_load drops while stalled.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle request for a full dense pass (ignored while busy)
//   stall             compute side not ready
//   row/col/channel   indices of the beat currently presented with weight_addr1/2
//   weight_addr1/2    weight-memory addresses of the current beat (addr2 = addr1 + 1, wrapping)
//   weight_load       read enable, high for every issued beat
//   valid_out         beat data present at compute inputs, MEM_LAT cycles after issue
//   valid_data2       second operand valid (low when the delayed beat was the last column)
//   channel_d         channel tag of the delayed beat
//   busy, done        run in progress / sticky completion flag
// Optional: define DENSE_SEQ_PERF_EN to add perf_cycles / perf_stalls counters.
module dense_sequencer #(
  parameter int OC              = 15,
  parameter int MAX_COL         = 12,
  parameter int POOL_W          = 7,
  parameter int WEIGHT_ADDR_LEN = 9,
  parameter int MEM_LAT         = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stall,
  output logic [4:0]                 row,
  output logic [4:0]                 col,
  output logic [4:0]                 channel,
  output logic [WEIGHT_ADDR_LEN:0]   weight_addr1,
  output logic [WEIGHT_ADDR_LEN:0]   weight_addr2,
  output logic                       weight_load,
  output logic                       valid_out,
  output logic                       valid_data2,
  output logic [4:0]                 channel_d,
  output logic                       busy,
`ifdef DENSE_SEQ_PERF_EN
  output logic [15:0]                perf_cycles,
  output logic [15:0]                perf_stalls,
`endif
  output logic                       done
);

  localparam int AW = WEIGHT_ADDR_LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               row_q, row_d;
  logic [4:0]               col_q, col_d;
  logic [4:0]               ch_q, ch_d;
  logic [AW-1:0]            addr1_q, addr1_d;
  logic [AW-1:0]            addr2_q, addr2_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [2:0]               drain_q, drain_d;

  // Issue pipeline, one entry per memory-latency stage: {valid, last_col, channel}.
  logic [MEM_LAT-1:0]       pv_q, pv_d;
  logic [MEM_LAT-1:0]       plc_q, plc_d;
  logic [MEM_LAT-1:0][4:0]  pch_q, pch_d;

  logic                     issue;
  logic                     pipe_en;
  logic                     accept;
  logic                     last_beat;
  logic                     addr_upd;
  logic [AW-1:0]            addr_calc;

  always_comb begin
    issue     = (state_q == S_RUN) && !stall;
    // Stall only matters while a pass is in flight; in IDLE/DONE the pipeline keeps flushing zeros.
    pipe_en   = !stall || (state_q == S_IDLE) || (state_q == S_DONE);
    accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_beat = (ch_q == 5'(OC)) && (row_q == 5'(MAX_COL)) && (col_q == 5'(MAX_COL));

    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    ch_d     = ch_q;
    drain_d  = drain_q;
    addr_upd = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_RUN;
          row_d    = 5'd0;
          col_d    = 5'd0;
          ch_d     = 5'd0;
          drain_d  = 3'd0;
          addr_upd = 1'b1;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (last_beat) begin
            // Indices hold on the final beat; only the pipeline still has work.
            state_d = S_DRAIN;
            drain_d = 3'd0;
          end else begin
            addr_upd = 1'b1;
            if (col_q == 5'(MAX_COL)) begin
              col_d = 5'd0;
              if (row_q == 5'(MAX_COL)) begin
                row_d = 5'd0;
                ch_d  = ch_q + 5'd1;
              end else begin
                row_d = row_q + 5'd1;
              end
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (drain_q == 3'(MEM_LAT - 1)) begin
            state_d = S_DONE;
          end else begin
            drain_d = drain_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address of the beat that will be presented next cycle, computed from the next indices.
    addr_calc = AW'(ch_d) * AW'(POOL_W * POOL_W)
              + AW'(row_d >> 1) * AW'(POOL_W)
              + AW'(col_d >> 1);
    addr1_d   = addr_upd ? addr_calc : addr1_q;
    addr2_d   = addr_upd ? (addr_calc + AW'(1)) : addr2_q;

    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);

    pv_d  = pv_q;
    plc_d = plc_q;
    pch_d = pch_q;
    if (pipe_en) begin
      pv_d[0]  = issue;
      plc_d[0] = (col_q == 5'(MAX_COL));
      pch_d[0] = ch_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv_d[i]  = pv_q[i-1];
        plc_d[i] = plc_q[i-1];
        pch_d[i] = pch_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= '0;
      pv_q    <= '0;
      plc_q   <= '0;
      pch_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drain_q <= drain_d;
      pv_q    <= pv_d;
      plc_q   <= plc_d;
      pch_q   <= pch_d;
    end
  end

  assign row          = row_q;
  assign col          = col_q;
  assign channel      = ch_q;
  assign weight_addr1 = addr1_q;
  assign weight_addr2 = addr2_q;
  // Combinational so a stall suppresses the read in the very cycle it is raised.
  assign weight_load  = issue;
  assign valid_out    = pv_q[MEM_LAT-1];
  assign valid_data2  = pv_q[MEM_LAT-1] & ~plc_q[MEM_LAT-1];
  assign channel_d    = pch_q[MEM_LAT-1];
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef DENSE_SEQ_PERF_EN
  logic [15:0] pcyc_q, pcyc_d;
  logic [15:0] pstl_q, pstl_d;

  always_comb begin
    pcyc_d = pcyc_q;
    pstl_d = pstl_q;
    if (accept) begin
      pcyc_d = 16'd0;
      pstl_d = 16'd0;
    end else if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      if (pcyc_q != 16'hFFFF) pcyc_d = pcyc_q + 16'd1;
      if (stall && (pstl_q != 16'hFFFF)) pstl_d = pstl_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcyc_q <= '0;
      pstl_q <= '0;
    end else begin
      pcyc_q <= pcyc_d;
      pstl_q <= pstl_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stalls = pstl_q;
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_dense_sequencer.sv
// tb_dense_sequencer: drives dense_sequencer through full passes with stalls, restarts and resets.
// Latency: expects the first beat the cycle busy rises and done MEM_LAT+1 cycles after the last beat.
// Backpressure: random and fixed stall windows; beats are checked against an index-arithmetic model.
module tb_dense_sequencer;
  localparam int OC      = 15;
  localparam int MAX_COL = 12;
  localparam int POOL_W  = 7;
  localparam int WAL     = 9;
  localparam int MEM_LAT = 1;
  localparam int SIDE    = MAX_COL + 1;
  localparam int N_BEATS = SIDE * SIDE * (OC + 1);
  localparam int AMOD    = 1 << (WAL + 1);
  localparam int BOUND   = 20000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           stall = 1'b0;
  logic [4:0]     row, col, channel, channel_d;
  logic [WAL:0]   weight_addr1, weight_addr2;
  logic           weight_load, valid_out, valid_data2, busy, done;
`ifdef DENSE_SEQ_PERF_EN
  logic [15:0]    perf_cycles, perf_stalls;
`endif

  dense_sequencer #(
    .OC(OC), .MAX_COL(MAX_COL), .POOL_W(POOL_W), .WEIGHT_ADDR_LEN(WAL), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .row(row), .col(col), .channel(channel),
    .weight_addr1(weight_addr1), .weight_addr2(weight_addr2),
    .weight_load(weight_load), .valid_out(valid_out), .valid_data2(valid_data2),
    .channel_d(channel_d), .busy(busy),
`ifdef DENSE_SEQ_PERF_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: beat k of a pass, from pure index arithmetic.
  function automatic int m_ch(int k);  return k / (SIDE * SIDE);   endfunction
  function automatic int m_row(int k); return (k / SIDE) % SIDE;   endfunction
  function automatic int m_col(int k); return k % SIDE;            endfunction
  function automatic int m_a1(int k);
    return (m_ch(k) * POOL_W * POOL_W + (m_row(k) / 2) * POOL_W + m_col(k) / 2) % AMOD;
  endfunction
  function automatic int m_a2(int k); return (m_a1(k) + 1) % AMOD; endfunction

  // Observation logs.
  int iss_ch[$], iss_row[$], iss_col[$], iss_a1[$], iss_a2[$];
  int vo_ch[$], vo_v2[$];
  int last_iss_cyc = 0;

  always @(negedge clk) begin
    if (weight_load === 1'b1) begin
      iss_ch.push_back(int'(channel));
      iss_row.push_back(int'(row));
      iss_col.push_back(int'(col));
      iss_a1.push_back(int'(weight_addr1));
      iss_a2.push_back(int'(weight_addr2));
      last_iss_cyc = cyc;
    end
    if (valid_out === 1'b1 && stall === 1'b0) begin
      vo_ch.push_back(int'(channel_d));
      vo_v2.push_back(int'(valid_data2));
    end
  end

  task automatic clear_logs();
    iss_ch.delete(); iss_row.delete(); iss_col.delete(); iss_a1.delete(); iss_a2.delete();
    vo_ch.delete(); vo_v2.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
    end
  endtask

  function automatic int iss_errs();
    int e = 0;
    for (int k = 0; k < iss_ch.size(); k++)
      if (iss_ch[k] != m_ch(k) || iss_row[k] != m_row(k) || iss_col[k] != m_col(k) ||
          iss_a1[k] != m_a1(k) || iss_a2[k] != m_a2(k)) e++;
    return e;
  endfunction

  function automatic int vo_errs();
    int e = 0;
    for (int k = 0; k < vo_ch.size(); k++)
      if (vo_ch[k] != m_ch(k) || vo_v2[k] != ((m_col(k) != MAX_COL) ? 1 : 0)) e++;
    return e;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({row, col, channel, channel_d} !== 20'd0)
      begin bad++; $display("FAIL reset_idx got %h exp 0", {row, col, channel, channel_d}); end
    total++;
    if ({weight_addr1, weight_addr2} !== 20'd0)
      begin bad++; $display("FAIL reset_addr got %h/%h exp 0/0", weight_addr1, weight_addr2); end
    total++;
    if ({weight_load, valid_out, valid_data2, busy, done} !== 5'd0)
      begin bad++; $display("FAIL reset_flags got %b exp 00000", {weight_load, valid_out, valid_data2, busy, done}); end
    @(posedge clk); #1 rst = 1'b1; stall = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, weight_load} !== 3'd0)
      begin bad++; $display("FAIL idle_hold got %b exp 000", {busy, done, weight_load}); end
    @(posedge clk); #1 stall = 1'b0;
  endtask

  task automatic test_full_pass();
    int dc, ones;
    clear_logs();
    pulse_start();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || weight_load !== 1'b1 || {channel, row, col} !== 15'd0)
      begin bad++; $display("FAIL first_beat got busy=%b wl=%b idx=%0d/%0d/%0d exp 1 1 0/0/0",
                            busy, weight_load, channel, row, col); end
    wait_done(dc);
    total++;
    if (dc < 0) begin bad++; $display("FAIL pass1_timeout got no done exp done"); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got %b exp 0", busy); end
    total++;
    if (dc - last_iss_cyc != MEM_LAT + 1)
      begin bad++; $display("FAIL done_latency got %0d exp %0d", dc - last_iss_cyc, MEM_LAT + 1); end
    total++;
    if (iss_ch.size() != N_BEATS)
      begin bad++; $display("FAIL pass1_beats got %0d exp %0d", iss_ch.size(), N_BEATS); end
    total++;
    if (iss_errs() != 0) begin bad++; $display("FAIL pass1_seq got %0d bad beats exp 0", iss_errs()); end
    total++;
    if (iss_a1[0] != 0 || iss_a2[0] != 1)
      begin bad++; $display("FAIL addr_first got %0d/%0d exp 0/1", iss_a1[0], iss_a2[0]); end
    total++;
    if (iss_a1[213] != 58 || iss_ch[213] != 1 || iss_row[213] != 3 || iss_col[213] != 5)
      begin bad++; $display("FAIL addr_c1r3c5 got %0d exp 58", iss_a1[213]); end
    total++;
    if (iss_a1[N_BEATS-1] != 783 || iss_a2[N_BEATS-1] != 784)
      begin bad++; $display("FAIL addr_last got %0d/%0d exp 783/784", iss_a1[N_BEATS-1], iss_a2[N_BEATS-1]); end
    total++;
    if (vo_ch.size() != N_BEATS || vo_errs() != 0)
      begin bad++; $display("FAIL pass1_valid got n=%0d err=%0d exp n=%0d err=0", vo_ch.size(), vo_errs(), N_BEATS); end
    ones = 0;
    foreach (vo_v2[k]) ones += vo_v2[k];
    total++;
    if (ones != MAX_COL * SIDE * (OC + 1) || vo_v2.size() - ones != SIDE * (OC + 1))
      begin bad++; $display("FAIL v2_count got %0d/%0d exp %0d/%0d", ones, vo_v2.size() - ones,
                            MAX_COL * SIDE * (OC + 1), SIDE * (OC + 1)); end
  endtask

  task automatic test_stall_and_busy_start();
    int nb = 0, stall_left = 0, dc = -1;
    bit start_next = 0, win_chk = 0, resume_chk = 0, triggered = 0;
    clear_logs();
    pulse_start();
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin dc = cyc; break; end
      if (win_chk) begin
        total++;
        if (weight_load !== 1'b0) begin bad++; $display("FAIL stall_wl got %b exp 0", weight_load); end
        total++;
        if ({channel, row, col} !== {5'd2, 5'd4, 5'd8})
          begin bad++; $display("FAIL stall_idx got %0d/%0d/%0d exp 2/4/8", channel, row, col); end
        total++;
        if (valid_out !== 1'b1 || channel_d !== 5'd2)
          begin bad++; $display("FAIL stall_vo got %b ch%0d exp 1 ch2", valid_out, channel_d); end
      end
      if (resume_chk && weight_load === 1'b1) begin
        total++;
        if ({channel, row, col} !== {5'd2, 5'd4, 5'd8})
          begin bad++; $display("FAIL resume_idx got %0d/%0d/%0d exp 2/4/8", channel, row, col); end
        resume_chk = 0;
      end
      if (weight_load === 1'b1) begin
        nb++;
        if (nb == 101) start_next = 1;
        if (!triggered && channel === 5'd2 && row === 5'd4 && col === 5'd7) begin
          triggered  = 1;
          stall_left = 5;
        end
      end
      @(posedge clk); #1;
      start      = start_next;
      start_next = 0;
      win_chk    = 0;
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
        win_chk = 1;
        if (stall_left == 0) resume_chk = 1;
      end else if (triggered && nb > 600) begin
        stall = ($urandom_range(0, 3) == 0);
      end else begin
        stall = 1'b0;
      end
    end
    @(posedge clk); #1 stall = 1'b0; start = 1'b0;
    total++;
    if (!triggered || dc < 0) begin bad++; $display("FAIL pass2_progress got trig=%0d dc=%0d exp 1 >=0", triggered, dc); end
    total++;
    if (iss_ch.size() != N_BEATS || iss_errs() != 0)
      begin bad++; $display("FAIL pass2_seq got n=%0d err=%0d exp n=%0d err=0", iss_ch.size(), iss_errs(), N_BEATS); end
    total++;
    if (vo_ch.size() != N_BEATS || vo_errs() != 0)
      begin bad++; $display("FAIL pass2_valid got n=%0d err=%0d exp n=%0d err=0", vo_ch.size(), vo_errs(), N_BEATS); end
  endtask

  task automatic test_restart_from_done();
    int dc;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_sticky got done=%b busy=%b exp 1 0", done, busy); end
    clear_logs();
    pulse_start();
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || {channel, row, col} !== 15'd0)
      begin bad++; $display("FAIL restart got done=%b busy=%b idx=%0d/%0d/%0d exp 0 1 0/0/0",
                            done, busy, channel, row, col); end
    wait_done(dc);
    total++;
    if (dc < 0 || iss_ch.size() != N_BEATS || iss_errs() != 0)
      begin bad++; $display("FAIL pass3_seq got dc=%0d n=%0d err=%0d exp n=%0d err=0", dc, iss_ch.size(), iss_errs(), N_BEATS); end
  endtask

  task automatic test_reset_mid_pass();
    int nb = 0, dc;
    bit hit = 0;
    clear_logs();
    pulse_start();
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (weight_load === 1'b1) nb++;
      if (nb == 1000) begin hit = 1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL reach_1000 got %0d beats exp 1000", nb); end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({row, col, channel, channel_d, weight_addr1, weight_addr2} !== 40'd0)
      begin bad++; $display("FAIL arst_data got %0d/%0d/%0d a=%0d/%0d exp all 0", channel, row, col, weight_addr1, weight_addr2); end
    total++;
    if ({weight_load, valid_out, valid_data2, busy, done} !== 5'd0)
      begin bad++; $display("FAIL arst_flags got %b exp 00000", {weight_load, valid_out, valid_data2, busy, done}); end
    @(posedge clk); #1 rst = 1'b1;
    clear_logs();
    pulse_start();
    @(negedge clk);
    total++;
    if (weight_load !== 1'b1 || busy !== 1'b1 || {channel, row, col} !== 15'd0)
      begin bad++; $display("FAIL fresh_start got wl=%b busy=%b idx=%0d/%0d/%0d exp 1 1 0/0/0",
                            weight_load, busy, channel, row, col); end
    wait_done(dc);
    total++;
    if (dc < 0 || iss_ch.size() != N_BEATS || iss_errs() != 0)
      begin bad++; $display("FAIL pass4_seq got dc=%0d n=%0d err=%0d exp n=%0d err=0", dc, iss_ch.size(), iss_errs(), N_BEATS); end
`ifdef DENSE_SEQ_PERF_EN
    total++;
    if (perf_cycles !== 16'(N_BEATS + MEM_LAT) || perf_stalls !== 16'd0)
      begin bad++; $display("FAIL perf got %0d/%0d exp %0d/0", perf_cycles, perf_stalls, N_BEATS + MEM_LAT); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_stall_and_busy_start();
    test_restart_from_done();
    test_reset_mid_pass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
